// File: rtl/count_pkg.sv
// Shared definitions for the loadable modulo-N counter family.
package count_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_e;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/count_tc.sv
// Terminal-value select and detect for a modulo-N up/down counter.
module count_tc
   import count_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int MODULUS = 256
) (
   input  logic [WIDTH-1:0] q,
   input  logic             dn,
   output logic [WIDTH-1:0] tv,
   output logic             at_tc
);

   localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);

   always_comb begin
      tv    = (dn == DIR_DN) ? '0 : QMAX;
      at_tc = (q == tv);
   end

endmodule

// File: rtl/count_ld_mod.sv
// Loadable modulo-N up/down counter with one-shot mode, compare match,
// sticky overflow and a combinational carry chain for cascading.
module count_ld_mod
   import count_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int MODULUS = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             ld,
   input  logic             ci,
   input  logic             dn,
   input  logic             oneshot,
   input  logic [WIDTH-1:0] cmp,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
   output logic             co,
   output logic             match,
   output logic             ovf,
   output logic             run
);

   localparam logic [WIDTH-1:0] QMAX    = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] tv;
   logic             at_tc;
   logic             cnt_en;
   logic             term_ev;
   logic             ovf_q, ovf_d;
   logic             match_q;

   count_tc #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_tc (
      .q     (q_q),
      .dn    (dn),
      .tv    (tv),
      .at_tc (at_tc)
   );

   assign run     = (state_q == ST_RUN);
   // Combinational so downstream stages step on the same edge.
   assign co      = ci & run & at_tc;
   assign cnt_en  = ci & run & ~ld;
   assign term_ev = cnt_en & at_tc;

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      // Set wins over a coincident clear.
      ovf_d   = term_ev | (ovf_q & ~clr_ovf);

      if (ld) begin
         q_d     = ({1'b0, d} < MOD_EXT) ? d : QMAX;
         state_d = ST_RUN;
      end else begin
         if (!oneshot) begin
            state_d = ST_RUN;
         end
         if (cnt_en) begin
            if (!at_tc) begin
               q_d = (dn == DIR_DN) ? (q_q - ONE) : (q_q + ONE);
            end else if (oneshot) begin
               q_d     = tv;
               state_d = ST_DONE;
            end else begin
               q_d = (dn == DIR_DN) ? QMAX : '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_RUN;
         q_q     <= '0;
         ovf_q   <= 1'b0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         ovf_q   <= ovf_d;
         match_q <= (q_q == cmp);
      end
   end

   assign q     = q_q;
   assign ovf   = ovf_q;
   assign match = match_q;

endmodule

// File: tb/tb_count_ld_mod.sv
// Self-checking bench for count_ld_mod (WIDTH = 8, MODULUS = 10).
module tb_count_ld_mod;

   localparam int W   = 8;
   localparam int MOD = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, ld, ci, dn, oneshot, clr_ovf;
   logic [W-1:0] d, cmp;
   logic [W-1:0] q;
   logic         co, match, ovf, run;

   // Cascade pair: lo digit feeds hi digit through co.
   logic         c_rst, c_ci;
   logic [W-1:0] lo_q, hi_q;
   logic         lo_co, hi_co, lo_match, hi_match, lo_ovf, hi_ovf, lo_run, hi_run;

   count_ld_mod #(.WIDTH(W), .MODULUS(MOD)) dut (
      .clk(clk), .rst(rst), .d(d), .ld(ld), .ci(ci), .dn(dn), .oneshot(oneshot),
      .cmp(cmp), .clr_ovf(clr_ovf), .q(q), .co(co), .match(match), .ovf(ovf), .run(run)
   );

   count_ld_mod #(.WIDTH(W), .MODULUS(MOD)) u_lo (
      .clk(clk), .rst(c_rst), .d(8'd0), .ld(1'b0), .ci(c_ci), .dn(1'b0), .oneshot(1'b0),
      .cmp(8'd0), .clr_ovf(1'b0), .q(lo_q), .co(lo_co), .match(lo_match), .ovf(lo_ovf),
      .run(lo_run)
   );

   count_ld_mod #(.WIDTH(W), .MODULUS(MOD)) u_hi (
      .clk(clk), .rst(c_rst), .d(8'd0), .ld(1'b0), .ci(lo_co), .dn(1'b0), .oneshot(1'b0),
      .cmp(8'd0), .clr_ovf(1'b0), .q(hi_q), .co(hi_co), .match(hi_match), .ovf(hi_ovf),
      .run(hi_run)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural reference: count value as an integer, run/ovf/match as flags.
   int m_q;
   bit m_run, m_ovf, m_match;
   logic last_co;

   typedef struct {
      bit rst, ld, ci, dn, os, clr;
      int d;
      bit co;
      int q;
      bit run, ovf;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_co();
      int tv = dn ? 0 : MOD - 1;
      return ci && m_run && (m_q == tv);
   endfunction

   task automatic model_edge();
      int tv;
      bit term;
      if (!rst) begin
         m_q = 0; m_run = 1; m_ovf = 0; m_match = 0;
         return;
      end
      tv      = dn ? 0 : MOD - 1;
      term    = m_run && ci && !ld && (m_q == tv);
      m_match = (m_q == int'(cmp));
      m_ovf   = term || (m_ovf && !clr_ovf);
      if (ld) begin
         m_q   = (int'(d) < MOD) ? int'(d) : MOD - 1;
         m_run = 1;
      end else if (!m_run) begin
         m_run = !oneshot;
      end else if (ci) begin
         if (term && oneshot) m_run = 0;
         else m_q = dn ? (m_q + MOD - 1) % MOD : (m_q + 1) % MOD;
      end
   endtask

   // Called at a falling edge; checks co before the edge and state after it.
   task automatic step(input bit r, l, c, dir, os, clr, input int dv, input int cv);
      rst = r; ld = l; ci = c; dn = dir; oneshot = os; clr_ovf = clr;
      d = W'(dv); cmp = W'(cv);
      #1;
      last_co = co;
      check("co", co, model_co());
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("q", q, m_q);
      check("run", run, m_run);
      check("ovf", ovf, m_ovf);
      check("match", match, m_match);
   endtask

   function automatic void add(bit r, l, c, dir, os, clr, int dv, bit eco, int eq, bit er, eo);
      vec_t v;
      v.rst = r; v.ld = l; v.ci = c; v.dn = dir; v.os = os; v.clr = clr; v.d = dv;
      v.co = eco; v.q = eq; v.run = er; v.ovf = eo;
      tbl.push_back(v);
   endfunction

   initial begin
      rst = 0; ld = 0; ci = 0; dn = 0; oneshot = 0; clr_ovf = 0; d = '0; cmp = '0;
      c_rst = 0; c_ci = 0;

      repeat (2) @(posedge clk);
      m_q = 0; m_run = 1; m_ovf = 0; m_match = 0;
      @(negedge clk);
      check("rst_q", q, 0);
      check("rst_run", run, 1);
      check("rst_ovf", ovf, 0);
      check("rst_match", match, 0);
      ci = 1; dn = 1; #1;
      check("rst_co_dn", co, 1);
      dn = 0; #1;
      check("rst_co_up", co, 0);
      ci = 0;

      // rst, ld, ci, dn, os, clr, d | co, q, run, ovf
      for (int i = 0; i < 12; i++) add(1, 0, 1, 0, 0, 0, 0, (i % 10) == 9, (i + 1) % 10, 1, i >= 9);
      add(1, 0, 0, 0, 0, 1, 0,   0, 2, 1, 0);
      add(1, 1, 0, 1, 0, 0, 3,   0, 3, 1, 0);
      add(1, 0, 1, 1, 0, 0, 0,   0, 2, 1, 0);
      add(1, 0, 1, 1, 0, 0, 0,   0, 1, 1, 0);
      add(1, 0, 1, 1, 0, 0, 0,   0, 0, 1, 0);
      add(1, 0, 1, 1, 0, 0, 0,   1, 9, 1, 1);
      add(1, 0, 1, 1, 0, 0, 0,   0, 8, 1, 1);
      add(1, 1, 0, 0, 1, 1, 7,   0, 7, 1, 0);
      add(1, 0, 1, 0, 1, 0, 0,   0, 8, 1, 0);
      add(1, 0, 1, 0, 1, 0, 0,   0, 9, 1, 0);
      add(1, 0, 1, 0, 1, 0, 0,   1, 9, 0, 1);
      add(1, 0, 1, 0, 1, 0, 0,   0, 9, 0, 1);
      add(1, 1, 0, 0, 1, 0, 2,   0, 2, 1, 1);
      add(1, 1, 0, 0, 0, 0, 200, 0, 9, 1, 1);
      add(1, 0, 0, 0, 0, 1, 0,   0, 9, 1, 0);
      add(1, 1, 1, 0, 0, 0, 4,   1, 4, 1, 0);
      add(1, 1, 0, 0, 0, 0, 9,   0, 9, 1, 0);
      add(1, 0, 1, 0, 0, 1, 0,   1, 0, 1, 1);
      add(1, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0);
      add(1, 1, 0, 0, 1, 0, 8,   0, 8, 1, 0);
      add(1, 0, 1, 0, 1, 0, 0,   0, 9, 1, 0);
      add(1, 0, 1, 0, 1, 0, 0,   1, 9, 0, 1);
      add(1, 0, 1, 0, 0, 0, 0,   0, 9, 1, 1);
      add(1, 0, 1, 0, 1, 0, 0,   1, 9, 0, 1);
      add(0, 1, 1, 0, 1, 0, 5,   0, 0, 1, 0);
      add(1, 0, 1, 1, 0, 0, 0,   1, 9, 1, 1);

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].ld, tbl[i].ci, tbl[i].dn, tbl[i].os, tbl[i].clr, tbl[i].d, 0);
         check($sformatf("tbl%0d_co", i), last_co, tbl[i].co);
         check($sformatf("tbl%0d_q", i), q, tbl[i].q);
         check($sformatf("tbl%0d_run", i), run, tbl[i].run);
         check($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ovf);
      end

      // match lags q by one cycle
      step(1, 1, 0, 0, 0, 0, 3, 5);
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 1, 0, 0, 0, 0, 5);
         check("match_seq", match, (3 + i) == 5);
      end

      // randomized against the reference model
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(63) != 0, $urandom_range(7) == 0, $urandom_range(3) != 0,
              $urandom_range(1) == 1, $urandom_range(2) == 0, $urandom_range(9) == 0,
              ($urandom_range(3) == 0) ? $urandom_range(255) : $urandom_range(MOD - 1),
              $urandom_range(MOD + 1));
      end

      // two-digit cascade 00..99 then wrap
      c_rst = 1; c_ci = 1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("cascade", int'(hi_q) * 10 + int'(lo_q), k % 100);
         if (k >= 99) check("cascade_ovf", hi_ovf, k == 100);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/count_ld_mod.md
# count_ld_mod

Parametrised loadable modulo-N up/down counter. It generalises the team's 8-bit loadable counter with configurable width and modulus, count direction, a one-shot mode, a registered compare-match output and a sticky overflow flag. `ci` and `co` form a ripple chain, so several instances cascade into wide or multi-digit counters (BCD digits, timer prescaler + main count). It sits in timer/prescaler datapaths driven by a single system clock.

## Interface
Parameters:
- `WIDTH`, 8, counter width in bits; legal range ≥ 2.
- `MODULUS`, 256, count range is 0..MODULUS-1; legal range 2 ≤ MODULUS ≤ 2^WIDTH.

Ports:
- `clk`  in  1  sole clock; every register updates on the rising edge.
- `rst`  in  1  reset: synchronous and active-low.
- `d`  in  WIDTH  load value.
- `ld`  in  1  synchronous load; also re-arms one-shot mode.
- `ci`  in  1  count enable / cascade carry-in.
- `dn`  in  1  direction: 0 = up, 1 = down.
- `oneshot`  in  1  1 = stop at terminal count, 0 = wrap (free-run).
- `cmp`  in  WIDTH  compare value.
- `clr_ovf`  in  1  clears `ovf`.
- `q`  out  WIDTH  count value (register).
- `co`  out  1  carry/borrow out (combinational).
- `match`  out  1  registered compare flag.
- `ovf`  out  1  sticky terminal-event flag.
- `run`  out  1  1 = counting state, 0 = halted (DONE).

## Operation
- Terminal value `tv`: MODULUS-1 when counting up, 0 when counting down.
- State machine: RUN, DONE.
  - Reset enters RUN.
  - RUN → DONE on a terminal event when `oneshot` = 1.
  - DONE → RUN on `ld`, or on any edge where `oneshot` = 0.
- Update priority: `rst` low > `ld` > count.
- Load:
  - `q` ← `d` if `d` < MODULUS; otherwise `q` ← MODULUS-1 (saturate).
  - `ld` together with `ci` performs the load only; there is no count and no terminal event.
- Count (RUN, `ci` = 1, `ld` = 0):
  - Up: `q` ← `q`+1 below MODULUS-1.
  - Down: `q` ← `q`-1 above 0.
  - Terminal event when `q` == `tv`:
    - free-run: up wraps to 0, down wraps to MODULUS-1;
    - one-shot: `q` holds and state goes to DONE.
- In DONE, `ci` is ignored and `q` holds.
- `co` = `ci` & RUN & (`q` == `tv`). It is purely combinational so cascaded stages step in the same edge.
- `ovf`:
  - set on every terminal event;
  - cleared by `clr_ovf`;
  - a simultaneous set and clear leaves `ovf` = 1.
- `match` ← (`q` == `cmp`), registered every cycle, independent of state.
- `dn` changes take effect on the next count edge; there is no pipeline.
- `run` = (state == RUN).
- Arithmetic is WIDTH bits with no overflow beyond MODULUS-1. `q` never leaves 0..MODULUS-1.

## Timing
- Reset values: `q` = 0, state = RUN (`run` = 1), `ovf` = 0, `match` = 0. `co` follows its equation (it is 1 if `ci` = 1 and `dn` = 1 in reset state).
- Reset asserted mid-count or in DONE takes effect on the next edge, overriding `ld`, `ci` and `clr_ovf`.
- `q`, `ovf` and state have 1-cycle latency from their inputs.
- `match` lags `q` by one cycle. `co` has 0 latency.
- One-shot: `co` pulses for exactly the one cycle in which the terminal edge occurs. It stays 0 in DONE even if `ci` = 1.

## Structure
- Shared package `count_pkg`:
  - state encoding `ST_RUN`/`ST_DONE`;
  - direction constants `DIR_UP`/`DIR_DN`.
- Sub-module `count_tc`: combinational terminal-value select and detect (`q`, `dn` → `tv`, `at_tc`). It is reused by future counter variants.
- The top holds the state register, the `q` register, `match` and `ovf`.

## Test plan
All scenarios use WIDTH = 8, MODULUS = 10.
- Free-run up, `ci` = 1 for 12 cycles from reset:
  - `q` runs 0..9, 0, 1;
  - `co` is high only while `q` = 9;
  - `ovf` is set at the 9→0 edge.
- Down with `d` = 3 loaded, `oneshot` = 0:
  - sequence 3, 2, 1, 0, 9;
  - `co` is high only at `q` = 0.
- One-shot up with `d` = 7:
  - `q` goes 7, 8, 9 and holds at 9; `run` drops the cycle after the terminal edge;
  - `co` is one pulse only;
  - `ld` with `d` = 2 then restores RUN and `q` = 2.
- Load edge cases:
  - `ld` with `d` = 200 → `q` = 9;
  - `ld` and `ci` together with `d` = 4 at `q` = 9 → `q` = 4, no `ovf` set, no count.
- Flags:
  - `cmp` = 5: `match` is high exactly one cycle after `q` = 5;
  - `clr_ovf` coinciding with a wrap leaves `ovf` = 1;
  - `clr_ovf` alone clears `ovf`.
- Reset and cascade:
  - `rst` low while in DONE at `q` = 9 → next edge `q` = 0, `run` = 1, `ovf` = 0;
  - two cascaded instances count 00..99 and wrap to 00.
